control_pipe: RTL and testbench

- Consumer end of the main-control interface. Takes the 8-bit control bundle produced by opcode decode in ID, together with the ID register indices.
- Carries the bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards, inserts bubbles and squashes on branch flush.
- Generates operand-forwarding selects for the EX-stage ALU muxes.

---
 rtl/riscv_ctrl_pkg.sv | 50 +++++
 rtl/hazard_fwd_unit.sv | 44 ++++
 rtl/control_pipe.sv | 125 ++++++++++++
 tb/tb_control_pipe.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the main-control bundle and the pipeline's reduced
// per-stage control records.
package riscv_ctrl_pkg;

  localparam int CTRL_ALUSRC    = 7;
  localparam int CTRL_MEMTOREG  = 6;
  localparam int CTRL_REGWRITE  = 5;
  localparam int CTRL_MEMREAD   = 4;
  localparam int CTRL_MEMWRITE  = 3;
  localparam int CTRL_BRANCH    = 2;
  localparam int CTRL_ALUOP_MSB = 1;
  localparam int CTRL_ALUOP_LSB = 0;

  localparam logic [7:0] NOP_BUNDLE = 8'h00;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [7:0] LW = 8'hF0;
  localparam logic [7:0] SW = 8'h88;
  localparam logic [7:0] R  = 8'h22;
  localparam logic [7:0] I  = 8'hA3;
  localparam logic [7:0] BR = 8'h05;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
    logic reg_write;
    logic memto_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic memto_reg;
  } wb_ctrl_t;

  // ALUSrc and ALUop are consumed in EX and are dropped here.
  function automatic mem_ctrl_t to_mem_ctrl(input logic [7:0] c);
    mem_ctrl_t m;
    m.mem_read  = c[CTRL_MEMREAD];
    m.mem_write = c[CTRL_MEMWRITE];
    m.branch    = c[CTRL_BRANCH];
    m.reg_write = c[CTRL_REGWRITE];
    m.memto_reg = c[CTRL_MEMTOREG];
    return m;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use detection and EX operand-forwarding selects.
module hazard_fwd_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [7:0]        ctrl_in,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              flush,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  logic uses_rs1, uses_rs2;

  // The younger producer in EX/MEM takes precedence over MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (mem_reg_write && mem_rd != '0 && mem_rd == rs)
      return FWD_MEM;
    else if (wb_reg_write && wb_rd != '0 && wb_rd == rs)
      return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    uses_rs1 = ctrl_in != NOP_BUNDLE;
    uses_rs2 = uses_rs1 && (!ctrl_in[CTRL_ALUSRC] || ctrl_in[CTRL_MEMWRITE]);
    stall    = !flush && ex_mem_read && ex_rd != '0 &&
               ((uses_rs1 && ex_rd == id_rs1) || (uses_rs2 && ex_rd == id_rs2));
    fwd_a    = fwd_sel(ex_rs1);
    fwd_b    = fwd_sel(ex_rs2);
  end

endmodule

// File: rtl/control_pipe.sv
// Carries the main-control bundle through ID/EX, EX/MEM and MEM/WB, with
// load-use bubbles, branch squash and a saturating stall counter.
module control_pipe
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [7:0]        id_ctrl,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  output logic              stall,
  output logic [7:0]        ex_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic              mem_Branch,
  output logic              mem_RegWrite,
  output logic              mem_MemtoReg,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_RegWrite,
  output logic              wb_MemtoReg,
  output logic [REG_AW-1:0] wb_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [7:0]        ctrl_in;
  logic [7:0]        ex_ctrl_q, ex_ctrl_d;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
  mem_ctrl_t         mem_ctrl_q, mem_ctrl_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  wb_ctrl_t          wb_ctrl_q, wb_ctrl_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign ctrl_in = id_valid ? id_ctrl : NOP_BUNDLE;

  hazard_fwd_unit #(.REG_AW(REG_AW)) u_hazard (
    .ctrl_in       (ctrl_in),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .flush         (flush),
    .ex_mem_read   (ex_ctrl_q[CTRL_MEMREAD]),
    .ex_rd         (ex_rd_q),
    .ex_rs1        (ex_rs1_q),
    .ex_rs2        (ex_rs2_q),
    .mem_reg_write (mem_ctrl_q.reg_write),
    .mem_rd        (mem_rd_q),
    .wb_reg_write  (wb_ctrl_q.reg_write),
    .wb_rd         (wb_rd_q),
    .stall         (stall),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  always_comb begin
    ex_ctrl_d   = ctrl_in;
    ex_rs1_d    = id_rs1;
    ex_rs2_d    = id_rs2;
    ex_rd_d     = id_rd;
    mem_ctrl_d  = to_mem_ctrl(ex_ctrl_q);
    mem_rd_d    = ex_rd_q;
    wb_ctrl_d   = '{reg_write: mem_ctrl_q.reg_write, memto_reg: mem_ctrl_q.memto_reg};
    wb_rd_d     = mem_rd_q;
    stall_cnt_d = stall_cnt_q;
    if (flush || stall) begin
      ex_ctrl_d = NOP_BUNDLE;
      ex_rs1_d  = '0;
      ex_rs2_d  = '0;
      ex_rd_d   = '0;
    end
    // Flush squashes EX too; the instruction already in MEM still retires.
    if (flush) begin
      mem_ctrl_d = '0;
      mem_rd_d   = '0;
    end else if (stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q   <= NOP_BUNDLE;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_rd_q     <= '0;
      mem_ctrl_q  <= '0;
      mem_rd_q    <= '0;
      wb_ctrl_q   <= '0;
      wb_rd_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_rd_q     <= ex_rd_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_rd_q    <= mem_rd_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_rd_q     <= wb_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_ctrl      = ex_ctrl_q;
  assign ex_rd        = ex_rd_q;
  assign mem_MemRead  = mem_ctrl_q.mem_read;
  assign mem_MemWrite = mem_ctrl_q.mem_write;
  assign mem_Branch   = mem_ctrl_q.branch;
  assign mem_RegWrite = mem_ctrl_q.reg_write;
  assign mem_MemtoReg = mem_ctrl_q.memto_reg;
  assign mem_rd       = mem_rd_q;
  assign wb_RegWrite  = wb_ctrl_q.reg_write;
  assign wb_MemtoReg  = wb_ctrl_q.memto_reg;
  assign wb_rd        = wb_rd_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_control_pipe.sv
// Directed vector table plus hand sequences for saturation and mid-stall reset.
module tb_control_pipe;
  import riscv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, flush;
  logic [7:0] id_ctrl;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        stall, mem_MemRead, mem_MemWrite, mem_Branch, mem_RegWrite, mem_MemtoReg;
  logic        wb_RegWrite, wb_MemtoReg;
  logic [7:0]  ex_ctrl;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  logic        s_stall, s_mr, s_mw, s_br, s_rw, s_m2r, s_wrw, s_wm2r;
  logic [7:0]  s_ex_ctrl;
  logic [4:0]  s_ex_rd, s_mem_rd, s_wb_rd;
  logic [1:0]  s_fa, s_fb;
  logic [1:0]  s_cnt;

  always #5 clk = ~clk;

  control_pipe #(.REG_AW(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
    .stall(stall), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_Branch(mem_Branch),
    .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg), .mem_rd(mem_rd),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_rd(wb_rd),
    .stall_cnt(stall_cnt)
  );

  control_pipe #(.REG_AW(5), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
    .stall(s_stall), .ex_ctrl(s_ex_ctrl), .ex_rd(s_ex_rd), .fwd_a(s_fa), .fwd_b(s_fb),
    .mem_MemRead(s_mr), .mem_MemWrite(s_mw), .mem_Branch(s_br),
    .mem_RegWrite(s_rw), .mem_MemtoReg(s_m2r), .mem_rd(s_mem_rd),
    .wb_RegWrite(s_wrw), .wb_MemtoReg(s_wm2r), .wb_rd(s_wb_rd),
    .stall_cnt(s_cnt)
  );

  typedef struct {
    logic       vld;
    logic [7:0] ctrl;
    logic [4:0] rs1, rs2, rd;
    logic       fl;
    logic       e_stall;
    logic [7:0] e_ex;
    logic [4:0] e_exrd;
    logic [4:0] e_mem;
    logic [4:0] e_memrd;
    logic [1:0] e_wb;
    logic [4:0] e_wbrd;
    logic [1:0] e_fa, e_fb;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [22];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d, input logic f);
    id_valid = v; id_ctrl = c; id_rs1 = a; id_rs2 = b; id_rd = d; flush = f;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {12'h0, ex_ctrl, mem_MemRead, mem_MemWrite, mem_Branch, mem_RegWrite,
        mem_MemtoReg, wb_RegWrite, wb_MemtoReg, stall, fwd_a, fwd_b}, 32'h0);
    chk({tag, "_rd"}, {17'h0, ex_rd, mem_rd, wb_rd}, 32'h0);
    chk({tag, "_cnt"}, {16'h0, stall_cnt}, 32'h0);
    chk({tag, "_satcnt"}, {30'h0, s_cnt}, 32'h0);
  endtask

  initial begin
    //        vld ctrl   rs1 rs2 rd fl  stl ex     exrd mem       memrd wb    wbrd fa     fb     cnt
    tbl[0]  = '{1, 8'hA3, 1, 0, 3, 0,  0, 8'hA3, 3, 5'b00000, 0, 2'b00, 0, 2'b00, 2'b00, 0};
    tbl[1]  = '{1, 8'hA3, 2, 0, 3, 0,  0, 8'hA3, 3, 5'b00010, 3, 2'b00, 0, 2'b00, 2'b00, 0};
    tbl[2]  = '{1, 8'h22, 3, 3, 4, 0,  0, 8'h22, 4, 5'b00010, 3, 2'b10, 3, 2'b10, 2'b10, 0};
    tbl[3]  = '{0, 8'hF0, 9, 9, 9, 0,  0, 8'h00, 9, 5'b00010, 4, 2'b10, 3, 2'b00, 2'b00, 0};
    tbl[4]  = '{1, 8'hA3, 1, 0, 7, 0,  0, 8'hA3, 7, 5'b00000, 9, 2'b10, 4, 2'b00, 2'b00, 0};
    tbl[5]  = '{1, 8'hA3, 2, 0, 7, 0,  0, 8'hA3, 7, 5'b00010, 7, 2'b00, 9, 2'b00, 2'b00, 0};
    tbl[6]  = '{0, 8'h00, 0, 0, 0, 0,  0, 8'h00, 0, 5'b00010, 7, 2'b10, 7, 2'b00, 2'b00, 0};
    tbl[7]  = '{1, 8'h22, 7, 7, 8, 0,  0, 8'h22, 8, 5'b00000, 0, 2'b10, 7, 2'b01, 2'b01, 0};
    tbl[8]  = '{1, 8'hF0, 1, 0, 0, 0,  0, 8'hF0, 0, 5'b00010, 8, 2'b00, 0, 2'b00, 2'b00, 0};
    tbl[9]  = '{1, 8'h22, 0, 0, 9, 0,  0, 8'h22, 9, 5'b10011, 0, 2'b10, 8, 2'b00, 2'b00, 0};
    tbl[10] = '{1, 8'hF0, 1, 0, 5, 0,  0, 8'hF0, 5, 5'b00010, 9, 2'b11, 0, 2'b00, 2'b00, 0};
    tbl[11] = '{1, 8'h22, 5, 1, 6, 0,  1, 8'h00, 0, 5'b10011, 5, 2'b10, 9, 2'b00, 2'b00, 1};
    tbl[12] = '{1, 8'h22, 5, 1, 6, 0,  0, 8'h22, 6, 5'b00000, 0, 2'b11, 5, 2'b01, 2'b00, 1};
    tbl[13] = '{1, 8'h05, 1, 2, 0, 0,  0, 8'h05, 0, 5'b00010, 6, 2'b00, 0, 2'b00, 2'b00, 1};
    tbl[14] = '{1, 8'hF0, 2, 0, 5, 0,  0, 8'hF0, 5, 5'b00100, 0, 2'b10, 6, 2'b00, 2'b00, 1};
    tbl[15] = '{1, 8'h22, 5, 1, 6, 1,  0, 8'h00, 0, 5'b00000, 0, 2'b00, 0, 2'b00, 2'b00, 1};
    tbl[16] = '{1, 8'h22, 5, 1, 6, 0,  0, 8'h22, 6, 5'b00000, 0, 2'b00, 0, 2'b00, 2'b00, 1};
    tbl[17] = '{1, 8'hF0, 0, 0, 6, 0,  0, 8'hF0, 6, 5'b00010, 6, 2'b00, 0, 2'b00, 2'b00, 1};
    tbl[18] = '{1, 8'h88, 1, 6, 0, 0,  1, 8'h00, 0, 5'b10011, 6, 2'b10, 6, 2'b00, 2'b00, 2};
    tbl[19] = '{1, 8'h88, 1, 6, 0, 0,  0, 8'h88, 0, 5'b00000, 0, 2'b11, 6, 2'b00, 2'b01, 2};
    tbl[20] = '{1, 8'hF0, 0, 0, 6, 0,  0, 8'hF0, 6, 5'b01000, 0, 2'b00, 0, 2'b00, 2'b00, 2};
    tbl[21] = '{1, 8'hA3, 1, 6, 2, 0,  0, 8'hA3, 2, 5'b10011, 6, 2'b00, 0, 2'b00, 2'b10, 2};

    // Reset held with random ID traffic: everything must stay zero.
    rst_n = 1'b0;
    drive(0, 8'h00, 0, 0, 0, 0);
    repeat (3) begin
      @(posedge clk); #1;
      drive(1'($urandom), 8'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
      #1 chk_all_zero("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 8'h00, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_all_zero("post_reset_nop");

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].vld, tbl[i].ctrl, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].fl);
      #1 chk($sformatf("v%0d_stall", i), {31'h0, stall}, {31'h0, tbl[i].e_stall});
      @(posedge clk); #1;
      chk($sformatf("v%0d_ex_ctrl", i), {24'h0, ex_ctrl}, {24'h0, tbl[i].e_ex});
      chk($sformatf("v%0d_ex_rd", i), {27'h0, ex_rd}, {27'h0, tbl[i].e_exrd});
      chk($sformatf("v%0d_mem_ctrl", i),
          {27'h0, mem_MemRead, mem_MemWrite, mem_Branch, mem_RegWrite, mem_MemtoReg},
          {27'h0, tbl[i].e_mem});
      chk($sformatf("v%0d_mem_rd", i), {27'h0, mem_rd}, {27'h0, tbl[i].e_memrd});
      chk($sformatf("v%0d_wb_ctrl", i), {30'h0, wb_RegWrite, wb_MemtoReg}, {30'h0, tbl[i].e_wb});
      chk($sformatf("v%0d_wb_rd", i), {27'h0, wb_rd}, {27'h0, tbl[i].e_wbrd});
      chk($sformatf("v%0d_fwd", i), {28'h0, fwd_a, fwd_b}, {28'h0, tbl[i].e_fa, tbl[i].e_fb});
      chk($sformatf("v%0d_cnt", i), {16'h0, stall_cnt}, {16'h0, tbl[i].e_cnt});
    end
    chk("table_satcnt", {30'h0, s_cnt}, 32'd2);

    // Five more load-use pairs: narrow counter pins at 3, wide one keeps counting.
    for (int p = 0; p < 5; p++) begin
      drive(1, LW, 0, 0, 5, 0);
      #1 chk($sformatf("sat%0d_lw_stall", p), {31'h0, stall}, 32'd0);
      @(posedge clk); #1;
      drive(1, R, 5, 0, 6, 0);
      #1 chk($sformatf("sat%0d_use_stall", p), {31'h0, stall}, 32'd1);
      @(posedge clk); #1;
      chk($sformatf("sat%0d_bubble", p), {24'h0, ex_ctrl}, 32'h0);
      chk($sformatf("sat%0d_cnt", p), {16'h0, stall_cnt}, 32'(3 + p));
      chk($sformatf("sat%0d_satcnt", p), {30'h0, s_cnt}, 32'd3);
      #1 chk($sformatf("sat%0d_clear", p), {31'h0, stall}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("sat%0d_ex_use", p), {24'h0, ex_ctrl}, {24'h0, R});
    end
    chk("sat_final_cnt", {16'h0, stall_cnt}, 32'd7);

    // Reset asserted while a stall is pending.
    drive(1, LW, 0, 0, 5, 0);
    @(posedge clk); #1;
    drive(1, R, 5, 0, 6, 0);
    #1 chk("mid_pre_stall", {31'h0, stall}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_release_stall", {31'h0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("mid_release_ex", {24'h0, ex_ctrl}, {24'h0, R});
    chk("mid_release_cnt", {16'h0, stall_cnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
